decoder_5_to_32_seq: RTL and testbench
======================================

// Module: decoder_5_to_32_seq
// PURPOSE
//  Registered 5-to-32 one-hot decoder, the inverse of the CPU's 32-to-5 bus-select encoding.
//  Converts a 5-bit register/source index into one-hot enables for the register file and bus.
//  Adds a valid/ready request port with one-cycle latency and a SWEEP mode.
//  SWEEP walks every valid index once per cycle, used to clear or initialise the register file.
// PARAMETERS
//  SEL_W      5   width of the index input
//  N_OUT      32  width of the one-hot output (2**SEL_W)
//  MAX_VALID  23  highest index that maps to a real one-hot line
//  NONE_CODE  31  index meaning "no selection" (all-zero output, no error)
// PORTS
//  clock       in   1      rising-edge clock
//  clear       in   1      asynchronous, active-low reset
//  in_valid    in   1      request valid
//  in_sel      in   SEL_W  index to decode; sampled when in_valid & in_ready
//  in_ready    out  1      block can accept a request this cycle
//  start       in   1      sweep request; sampled in IDLE only
//  abort       in   1      terminate a sweep in progress
//  out_onehot  out  N_OUT  registered one-hot enable vector
//  out_valid   out  1      out_onehot/err valid this cycle (1-cycle pulse per result)
//  err         out  1      index was in MAX_VALID+1 .. NONE_CODE-1 (24..30)
//  busy        out  1      sweep in progress
//  sweep_idx   out  SEL_W  index currently driven during sweep
// BEHAVIOUR
//  Reset (clear=0, async)
//   - state=IDLE; out_onehot=0, out_valid=0, err=0, busy=0, sweep_idx=0.
//   - Deasserting clear takes effect at the next clock edge.
//   - Reset mid-sweep abandons the sweep with no further pulses.
//  FSM states: IDLE, SWEEP.
//  Ready and priority
//   - in_ready = (state==IDLE) & ~start, combinational.
//   - start has priority over in_valid in the same cycle; that request is not accepted.
//  IDLE, request accepted (in_valid & in_ready): result is registered for the next cycle (latency 1).
//   - in_sel <= MAX_VALID: out_onehot = 1<<in_sel, err=0.
//   - in_sel == NONE_CODE: out_onehot = 0, err=0.
//   - otherwise: out_onehot = 0, err=1.
//   - out_valid=1 in every case.
//  IDLE, no request: out_valid=0, err=0, out_onehot=0.
//   - Back-to-back requests give back-to-back pulses, one result per cycle.
//  IDLE & start -> SWEEP
//   - sweep_idx=0, busy=1.
//   - Next cycle: out_onehot = 1<<0, out_valid=1.
//  SWEEP
//   - Each cycle drives out_onehot = 1<<sweep_idx with out_valid=1, then sweep_idx increments.
//   - After index MAX_VALID is driven: -> IDLE, busy=0, sweep_idx=0.
//   - A full sweep is MAX_VALID+1 = 24 consecutive valid cycles.
//   - No wrap past MAX_VALID; indices 24..31 are never driven during a sweep.
//   - abort=1 in SWEEP: next edge -> IDLE, out_valid=0, out_onehot=0, busy=0, no more pulses.
//   - start and in_valid are ignored while in SWEEP (in_ready=0).
//  Output invariants
//   - out_onehot has at most one bit set in every cycle.
//   - err=1 implies out_valid=1 and out_onehot=0.
// TESTING
//  1. Reset then idle: all outputs 0, in_ready=1.
//     - in_sel=7, in_valid=1 for one cycle -> next cycle out_onehot=32'h80, out_valid=1, err=0.
//  2. Out-of-range and none codes:
//     - in_sel=24 -> out_onehot=0, err=1, out_valid=1.
//     - in_sel=31 -> out_onehot=0, err=0, out_valid=1.
//     - in_sel=23 -> out_onehot=32'h0080_0000.
//  3. Full sweep from start pulse:
//     - 24 consecutive out_valid cycles, out_onehot 32'h1 through 32'h0080_0000.
//     - busy drops and in_ready rises the cycle after index 23.
//  4. start and in_valid(sel=3) in the same cycle:
//     - sweep begins and in_ready=0.
//     - The request is not accepted; no 32'h8 pulse outside the sweep sequence.
//  5. abort at sweep_idx=5 -> no further out_valid; IDLE and in_ready=1 next cycle.
//  6. clear asserted mid-sweep (idx=10):
//     - Outputs go 0 immediately, asynchronously.
//     - After release, the block is in IDLE and a fresh request decodes correctly.

Source files
------------

// File: rtl/decoder_5_to_32_seq.sv
// Registered 5-to-32 one-hot decoder with a valid/ready request port and a SWEEP
// mode that walks every real index once, for clearing or initialising the register file.
//
// state | meaning
// IDLE  | accept one decode request per cycle; start launches a sweep
// SWEEP | drive 1<<sweep_idx each cycle from 0 up to MAX_VALID, abort exits early
module decoder_5_to_32_seq #(
  parameter int SEL_W     = 5,
  parameter int N_OUT     = 32,
  parameter int MAX_VALID = 23,
  parameter int NONE_CODE = 31
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic [SEL_W-1:0] in_sel_i,
  output logic             in_ready_o,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [N_OUT-1:0] out_onehot_o,
  output logic             out_valid_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [SEL_W-1:0] sweep_idx_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic [N_OUT-1:0]   onehot_q, onehot_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               accept;
  logic               sweep_last;

  assign in_ready_o = (state_q == IDLE) && !start_i;
  assign accept     = in_valid_i && in_ready_o;
  assign sweep_last = (sweep_idx_q == SEL_W'(MAX_VALID));

  always_ff @(posedge clock_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
      onehot_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      onehot_q    <= onehot_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = SWEEP;
      end
      SWEEP: begin
        if (abort_i || sweep_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Indices between MAX_VALID and NONE_CODE have no enable line and flag err.
  always_comb begin
    onehot_d    = '0;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      IDLE: begin
        sweep_idx_d = '0;
        if (accept) begin
          valid_d = 1'b1;
          if (in_sel_i <= SEL_W'(MAX_VALID)) begin
            onehot_d = N_OUT'(1) << in_sel_i;
          end else if (in_sel_i != SEL_W'(NONE_CODE)) begin
            err_d = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (abort_i) begin
          sweep_idx_d = '0;
        end else begin
          onehot_d    = N_OUT'(1) << sweep_idx_q;
          valid_d     = 1'b1;
          sweep_idx_d = sweep_last ? '0 : sweep_idx_q + SEL_W'(1);
        end
      end
      default: sweep_idx_d = '0;
    endcase
  end

  assign out_onehot_o = onehot_q;
  assign out_valid_o  = valid_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q == SWEEP);
  assign sweep_idx_o  = sweep_idx_q;

endmodule

// File: tb/tb_decoder_5_to_32_seq.sv
// Self-checking bench for decoder_5_to_32_seq: decode table, directed sweep/abort/reset
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_decoder_5_to_32_seq;
  localparam int SEL_W     = 5;
  localparam int N_OUT     = 32;
  localparam int MAX_VALID = 23;
  localparam int NONE_CODE = 31;

  logic             clk = 1'b0;
  logic             clear_n;
  logic             in_valid;
  logic [SEL_W-1:0] in_sel;
  logic             in_ready;
  logic             start;
  logic             abort;
  logic [N_OUT-1:0] out_onehot;
  logic             out_valid;
  logic             err;
  logic             busy;
  logic [SEL_W-1:0] sweep_idx;

  always #5 clk = ~clk;

  decoder_5_to_32_seq #(
    .SEL_W(SEL_W), .N_OUT(N_OUT), .MAX_VALID(MAX_VALID), .NONE_CODE(NONE_CODE)
  ) dut (
    .clock_i(clk), .clear_i(clear_n), .in_valid_i(in_valid), .in_sel_i(in_sel),
    .in_ready_o(in_ready), .start_i(start), .abort_i(abort), .out_onehot_o(out_onehot),
    .out_valid_o(out_valid), .err_o(err), .busy_o(busy), .sweep_idx_o(sweep_idx)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: sweeping flag plus the next index the sweep will emit.
  bit          m_sweep = 1'b0;
  int          m_idx   = 0;
  logic [31:0] e_oh;
  logic        e_v;
  logic        e_e;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] exp_oh;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives inputs, checks in_ready mid-cycle, then outputs after the edge.
  task automatic cycle(input logic v, input logic [4:0] s, input logic st, input logic ab,
                       input string tag);
    in_valid = v; in_sel = s; start = st; abort = ab;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(!m_sweep && !st));
    e_oh = 0; e_v = 0; e_e = 0;
    if (!m_sweep) begin
      if (st) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end else if (v) begin
        e_v = 1'b1;
        if (int'(s) <= MAX_VALID) e_oh = 32'd1 << s;
        else if (int'(s) != NONE_CODE) e_e = 1'b1;
      end
    end else if (ab) begin
      m_sweep = 1'b0;
      m_idx   = 0;
    end else begin
      e_oh = 32'd1 << m_idx;
      e_v  = 1'b1;
      m_idx++;
      if (m_idx > MAX_VALID) begin
        m_sweep = 1'b0;
        m_idx   = 0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, " out_onehot"}, out_onehot, e_oh);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_v));
    chk({tag, " err"}, 32'(err), 32'(e_e));
    chk({tag, " busy"}, 32'(busy), 32'(m_sweep));
    chk({tag, " sweep_idx"}, 32'(sweep_idx), 32'(m_idx));
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int pulses;
    clear_n = 1'b0; in_valid = 1'b0; in_sel = '0; start = 1'b0; abort = 1'b0;

    vecs.push_back('{5'd7,  32'h0000_0080, 1'b0});
    vecs.push_back('{5'd24, 32'h0000_0000, 1'b1});
    vecs.push_back('{5'd31, 32'h0000_0000, 1'b0});
    vecs.push_back('{5'd23, 32'h0080_0000, 1'b0});
    vecs.push_back('{5'd0,  32'h0000_0001, 1'b0});
    vecs.push_back('{5'd30, 32'h0000_0000, 1'b1});
    vecs.push_back('{5'd15, 32'h0000_8000, 1'b0});

    #12;
    chk("reset out_onehot", out_onehot, 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset sweep_idx", 32'(sweep_idx), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    idle("idle");

    // Decode table: one request, then an idle cycle to see the pulse drop.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].sel, 1'b0, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table onehot", i), out_onehot, vecs[i].exp_oh);
      chk($sformatf("vec%0d table err", i), 32'(err), 32'(vecs[i].exp_err));
      idle($sformatf("vec%0d gap", i));
    end

    // Back-to-back requests.
    for (int k = 0; k < 4; k++) cycle(1'b1, 5'(k * 3), 1'b0, 1'b0, "b2b");

    // Full sweep: 24 consecutive pulses 1<<0 .. 1<<23, then idle.
    cycle(1'b0, 5'd0, 1'b1, 1'b0, "sweep start");
    pulses = 0;
    for (int k = 0; k <= MAX_VALID; k++) begin
      idle("sweep");
      chk($sformatf("sweep step%0d onehot", k), out_onehot, 32'd1 << k);
      if (out_valid) pulses++;
    end
    chk("sweep pulse count", 32'(pulses), 32'd24);
    chk("sweep end busy", 32'(busy), 32'h0);
    chk("sweep end in_ready", 32'(in_ready), 32'h1);
    idle("after sweep");

    // start and in_valid together: start wins, request dropped.
    cycle(1'b1, 5'd3, 1'b1, 1'b0, "start+req");
    chk("start+req out_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k <= MAX_VALID; k++) cycle(1'b1, 5'd3, 1'b1, 1'b0, "start+req sweep");
    idle("start+req done");

    // Abort when sweep_idx reaches 5.
    cycle(1'b0, 5'd0, 1'b1, 1'b0, "abort start");
    for (int k = 0; k < 40 && sweep_idx != 5'd5; k++) idle("abort run");
    chk("abort reached idx5", 32'(sweep_idx), 32'd5);
    cycle(1'b0, 5'd0, 1'b0, 1'b1, "abort");
    chk("abort no pulse", 32'(out_valid), 32'h0);
    idle("post abort");
    idle("post abort2");

    // Asynchronous clear mid-sweep at idx 10.
    cycle(1'b0, 5'd0, 1'b1, 1'b0, "clr start");
    for (int k = 0; k < 40 && sweep_idx != 5'd10; k++) idle("clr run");
    chk("clr reached idx10", 32'(sweep_idx), 32'd10);
    #2;
    clear_n = 1'b0;
    #1;
    chk("clr async onehot", out_onehot, 32'h0);
    chk("clr async valid", 32'(out_valid), 32'h0);
    chk("clr async busy", 32'(busy), 32'h0);
    chk("clr async sweep_idx", 32'(sweep_idx), 32'h0);
    m_sweep = 1'b0;
    m_idx   = 0;
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    chk("clr released valid", 32'(out_valid), 32'h0);
    cycle(1'b1, 5'd12, 1'b0, 1'b0, "clr fresh req");
    chk("clr fresh onehot", out_onehot, 32'h0000_1000);
    idle("clr fresh gap");

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0), "rand");
      if ($countones(out_onehot) > 1) chk("rand onehot invariant", 32'($countones(out_onehot)), 32'd1);
      if (err && (!out_valid || out_onehot != 0)) chk("rand err invariant", {out_onehot[30:0], out_valid}, 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
